// File: rtl/addition_result_queue_if.sv
// rtl/addition_result_queue_if.sv - result stream into and out of the addition result queue
// Signals:
//   in_valid/sum/flags        : adder result stream (no ready; the adder cannot stall)
//   out_valid/out_ready       : queue head handshake
//   out_sum/out_flags         : queue head entry
// Modports: master = producer/consumer side, slave = queue side.
interface addition_result_queue_if;
  logic        in_valid;
  logic [29:0] sum;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_sum;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, sum, flags, out_ready,
    input  out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, sum, flags, out_ready,
    output out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/addition_result_queue.sv
// rtl/addition_result_queue.sv - saturating result FIFO with drop and overflow statistics
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-low
//   q           : result stream in / head handshake out (slave modport)
//   sat_en      : saturate overflowed results on write
//   clr_stats   : clears ovf_count, drop_count, drop_sticky (wins over same-cycle update)
//   level       : current occupancy
//   drop_sticky : a result was dropped since the last clear
//   ovf_count   : accepted results with flags[1:0] != 0, saturating
//   drop_count  : dropped results, saturating
module addition_result_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  addition_result_queue_if.slave   q,
  input  logic                     sat_en,
  input  logic                     clr_stats,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_sticky,
  output logic [CW-1:0]            ovf_count,
  output logic [CW-1:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [29:0]   mem_sum   [DEPTH];
  logic [3:0]    mem_flags [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          out_valid_q;
  logic [29:0]   head_sum_q;
  logic [3:0]    head_flags_q;
  logic          sticky_q;
  logic [CW-1:0] ovf_q, drop_q;

  logic          pop, push_acc, drop, ovf_in;
  logic [29:0]   wr_sum;
  logic [3:0]    wr_flags;
  logic [AW-1:0] rd_next;
  logic [LW-1:0] level_next;
  logic [29:0]   head_sum_next;
  logic [3:0]    head_flags_next;

  // Input flags[3] carries no meaning here and is forced to 0 on output.
  logic unused_flag3;
  assign unused_flag3 = q.flags[3];

  always_comb begin
    pop      = out_valid_q && q.out_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    push_acc = q.in_valid && ((level_q != FULL_LVL) || pop);
    drop     = q.in_valid && !push_acc;
    ovf_in   = (q.flags[1:0] != 2'b00);
  end

  // Saturation of the entry being written; unsigned carry takes priority.
  always_comb begin
    wr_sum   = q.sum;
    wr_flags = {2'b00, q.flags[1:0]};
    if (sat_en) begin
      if (q.flags[0]) begin
        wr_sum      = 30'h3FFF_FFFF;
        wr_flags[2] = 1'b1;
      end else if (q.flags[1]) begin
        // Sign bit of the wrapped result is opposite to the true sign.
        wr_sum      = q.sum[29] ? 30'h1FFF_FFFF : 30'h2000_0000;
        wr_flags[2] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    case ({push_acc, pop})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  // Head registers track the entry at the next read pointer. When that slot
  // is being written this cycle (queue empty after this edge's pop), the new
  // entry is taken directly; with no entry left the last head value is held.
  always_comb begin
    head_sum_next   = head_sum_q;
    head_flags_next = head_flags_q;
    if (level_next != '0) begin
      if (push_acc && (wr_ptr == rd_next)) begin
        head_sum_next   = wr_sum;
        head_flags_next = wr_flags;
      end else begin
        head_sum_next   = mem_sum[rd_next];
        head_flags_next = mem_flags[rd_next];
      end
    end
  end

  // Storage needs no reset: it is only read while level covers the slot.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      mem_sum[wr_ptr]   <= wr_sum;
      mem_flags[wr_ptr] <= wr_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      out_valid_q  <= 1'b0;
      head_sum_q   <= '0;
      head_flags_q <= '0;
      sticky_q     <= 1'b0;
      ovf_q        <= '0;
      drop_q       <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_next;
      level_q      <= level_next;
      out_valid_q  <= (level_next != '0);
      head_sum_q   <= head_sum_next;
      head_flags_q <= head_flags_next;

      if (clr_stats) begin
        sticky_q <= 1'b0;
        ovf_q    <= '0;
        drop_q   <= '0;
      end else begin
        if (drop) sticky_q <= 1'b1;
        if (drop && (drop_q != CNT_MAX)) drop_q <= drop_q + 1'b1;
        if (push_acc && ovf_in && (ovf_q != CNT_MAX)) ovf_q <= ovf_q + 1'b1;
      end
    end
  end

  assign q.out_valid = out_valid_q;
  assign q.out_sum   = head_sum_q;
  assign q.out_flags = head_flags_q;
  assign level       = level_q;
  assign drop_sticky = sticky_q;
  assign ovf_count   = ovf_q;
  assign drop_count  = drop_q;

endmodule
